// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher sequencer: thermometer lamp bank stepped once per tick, with flick kickback.
// Optional BOUND_FLASHER_FLICK_SYNC_EN passes flick through a 2-flop synchronizer.
module bound_flasher_ctrl #(
  parameter int NUM_LAMPS = 16,
  parameter int LOW_MARK  = 6,
  parameter int HIGH_MARK = 11,
  parameter int CNT_W     = $clog2(NUM_LAMPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 flick,
  output logic [NUM_LAMPS-1:0] lamps,
  output logic [2:0]           phase,
  output logic                 busy
);

  if (LOW_MARK < 2 || LOW_MARK >= HIGH_MARK || HIGH_MARK >= NUM_LAMPS ||
      CNT_W < $clog2(NUM_LAMPS + 1)) begin : g_param_check
    $fatal(1, "bound_flasher_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    KB0  = 3'd2,
    DN1  = 3'd3,
    UP2  = 3'd4,
    DN2  = 3'd5,
    UP3  = 3'd6,
    DN3  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_MARK);
  localparam logic [CNT_W-1:0] LOWM1_C = CNT_W'(LOW_MARK - 1);
  localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_LAMPS);
  localparam logic [NUM_LAMPS-1:0] ONES_C = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc, cnt_dec;
  logic             flick_s;

`ifdef BOUND_FLASHER_FLICK_SYNC_EN
  logic flick_meta_q, flick_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flick_meta_q <= 1'b0;
      flick_sync_q <= 1'b0;
    end else begin
      flick_meta_q <= flick;
      flick_sync_q <= flick_meta_q;
    end
  end

  assign flick_s = flick_sync_q;
`else
  assign flick_s = flick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + ONE_C;
  assign cnt_dec = cnt_q - ONE_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (flick_s) begin
            cnt_d   = ONE_C;
            state_d = UP1;
          end
        end
        UP1: begin
          if (flick_s && (cnt_q == LOW_C || cnt_q == HIGH_C)) begin
            cnt_d   = cnt_dec;
            state_d = KB0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == NUM_C) state_d = DN1;
          end
        end
        KB0: begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = UP1;
        end
        DN1: begin
          // Entered at LOW_MARK-1 by an UP2 kickback: turn around without stepping.
          if (cnt_q == LOWM1_C) begin
            state_d = UP2;
          end else begin
            cnt_d = cnt_dec;
            if (cnt_dec == LOWM1_C) state_d = UP2;
          end
        end
        UP2: begin
          if (flick_s && cnt_q == LOW_C) begin
            cnt_d   = cnt_dec;
            state_d = DN1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == HIGH_C) state_d = DN2;
          end
        end
        DN2: begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = UP3;
        end
        UP3: begin
          cnt_d = cnt_inc;
          if (cnt_inc == LOW_C) state_d = DN3;
        end
        DN3: begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    lamps = ~(ONES_C << cnt_q);
    phase = state_q;
    busy  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Scoreboard bench for bound_flasher_ctrl: waypoint-queue reference model, per-cycle expected outputs.
module tb_bound_flasher_ctrl;

  localparam int N  = 16;
  localparam int LO = 6;
  localparam int HI = 11;
`ifdef BOUND_FLASHER_FLICK_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          flick = 1'b0;
  logic [N-1:0]  lamps;
  logic [2:0]    phase;
  logic          busy;

  bound_flasher_ctrl #(.NUM_LAMPS(N), .LOW_MARK(LO), .HIGH_MARK(HI)) dut (
    .clk(clk), .rst(rst), .tick(tick), .flick(flick),
    .lamps(lamps), .phase(phase), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: the pattern is a list of count waypoints, each tagged with the phase it runs in.
  typedef struct {
    int tgt;
    int ph;
    bit hold;
  } wp_t;

  typedef struct packed {
    logic [N-1:0] l;
    logic [2:0]   p;
    logic         b;
  } exp_t;

  wp_t  wq[$];
  exp_t sq[$];
  int   m_cnt = 0;
  bit   fh1 = 1'b0, fh2 = 1'b0;
  int   n_chk = 0, n_fail = 0;

  function automatic int m_phase();
    return (wq.size() > 0) ? wq[0].ph : 0;
  endfunction

  function automatic void m_tick(bit f);
    if (wq.size() == 0) begin
      if (f) begin
        m_cnt = 1;
        wq.push_back('{tgt: N,      ph: 1, hold: 1'b0});
        wq.push_back('{tgt: LO - 1, ph: 3, hold: 1'b0});
        wq.push_back('{tgt: HI,     ph: 4, hold: 1'b0});
        wq.push_back('{tgt: 0,      ph: 5, hold: 1'b0});
        wq.push_back('{tgt: LO,     ph: 6, hold: 1'b0});
        wq.push_back('{tgt: 0,      ph: 7, hold: 1'b0});
      end
      return;
    end
    if (m_cnt == wq[0].tgt) begin
      void'(wq.pop_front());
      return;
    end
    if (f && wq[0].ph == 1 && (m_cnt == LO || m_cnt == HI))
      wq.push_front('{tgt: 0, ph: 2, hold: 1'b0});
    else if (f && wq[0].ph == 4 && m_cnt == LO)
      wq.push_front('{tgt: LO - 1, ph: 3, hold: 1'b1});
    m_cnt += (wq[0].tgt > m_cnt) ? 1 : -1;
    if (m_cnt == wq[0].tgt && !wq[0].hold) void'(wq.pop_front());
  endfunction

  function automatic void m_step(bit r, bit t, bit f);
    bit feff;
    feff = SYNC ? fh2 : f;
    if (r) begin
      m_cnt = 0;
      wq.delete();
    end else if (t) begin
      m_tick(feff);
    end
    if (SYNC) begin
      fh2 = r ? 1'b0 : fh1;
      fh1 = r ? 1'b0 : f;
    end
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    logic [31:0] v;
    v   = (32'd1 << m_cnt) - 32'd1;
    e.l = v[N-1:0];
    e.p = 3'(m_phase());
    e.b = (wq.size() > 0);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit t, input bit f);
    rst   = r;
    tick  = t;
    flick = f;
    m_step(r, t, f);
    sq.push_back(m_exp());
    @(posedge clk);
    #2;
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no progress, required model condition", name);
  endtask

  task automatic start_seq();
    int n = 0;
    while (m_phase() == 0 && n < 20) begin
      cyc(1'b0, 1'b1, 1'b1);
      n++;
    end
    if (m_phase() == 0) bound_fail("start");
  endtask

  // Monitor: one expected response per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        n_chk++;
        if (lamps !== e.l) begin
          n_fail++;
          $display("FAIL lamps @%0t: got %h expected %h", $time, lamps, e.l);
        end
        n_chk++;
        if (phase !== e.p) begin
          n_fail++;
          $display("FAIL phase @%0t: got %0d expected %0d", $time, phase, e.p);
        end
        n_chk++;
        if (busy !== e.b) begin
          n_fail++;
          $display("FAIL busy @%0t: got %b expected %b", $time, busy, e.b);
        end
      end
    end
  end

  initial begin
    int n;
    // reset, then idle with flick low for 20 ticks
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (20) begin
      cyc(1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end

    // full uninterrupted run with irregular tick spacing
    start_seq();
    for (int i = 0; i < 62; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    end

    // flick rises one cycle before a tick, then held
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    if (m_phase() == 0) start_seq();

    // UP1 kickback at LOW_MARK
    n = 0;
    while (!(m_phase() == 1 && m_cnt == LO) && n < 200) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 200) bound_fail("up1_reach");
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // UP2 kickback at LOW_MARK
    n = 0;
    while (!(m_phase() == 4 && m_cnt == LO) && n < 200) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 200) bound_fail("up2_reach");
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // reset together with tick mid-sequence (DN1, cnt=12)
    cyc(1'b1, 1'b0, 1'b0);
    start_seq();
    n = 0;
    while (!(m_phase() == 3 && m_cnt == 12) && n < 200) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 200) bound_fail("dn1_reach");
    cyc(1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // flick high without tick: nothing moves
    start_seq();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3));

    cyc(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (sq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
